// File: rtl/demux14_lane_buffer_pkg.sv
// Shared lane count, select width and lane state encoding for the demux lane buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux14_lane_buffer_lane_reg.sv
// One-entry holding register with valid/ready output handshake for a single lane.
// Latency: a word loaded at edge N is presented on y with y_valid set after edge N.
// Backpressure: holds y stable while y_valid=1 and y_ready=0; load and pop may coincide.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears state and data
//   load     capture din this cycle (caller guarantees the lane can accept)
//   din      word to capture
//   y        held word
//   y_valid  lane holds a word
//   y_ready  consumer accepts the held word this cycle
module demux_lane_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    lane_state_t state;
    lane_state_t state_nxt;
    logic        pop;

    assign pop     = y_valid & y_ready;
    assign y_valid = (state == LANE_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LANE_EMPTY;
            y     <= '0;
        end else begin
            state <= state_nxt;
            // Data only moves on a load; after a pop without reload, y keeps its last value.
            if (load) begin
                y <= din;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LANE_EMPTY: begin
                if (load) begin
                    state_nxt = LANE_FULL;
                end
            end
            LANE_FULL: begin
                // Pop together with load refills the slot in the same edge: no bubble.
                if (pop && !load) begin
                    state_nxt = LANE_EMPTY;
                end
            end
            default: state_nxt = LANE_EMPTY;
        endcase
    end

endmodule

// File: rtl/demux14_lane_buffer.sv
// Registered 1:4 lane buffer: routes each accepted word into the selected lane's holding register.
// Latency: 1 cycle from acceptance to y<sel>/y_valid.
// Backpressure: in_ready drops when the selected lane is full and its consumer is stalled (head-of-line).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   d, in_valid       input word and its qualifier
//   in_ready          selected lane can take a word this cycle (independent of in_valid)
//   s1, s0            lane select {s1,s0}; ignored when DEMUX_RR_EN is defined
//   y0..y3            registered lane data
//   y_valid, y_ready  per-lane handshake, bit i belongs to yi
//   busy              any lane holds a word
//
// Build option DEMUX_RR_EN: lane select comes from an internal round-robin pointer that
// advances on each accepted word instead of from s1/s0. Port list is identical either way.
module demux14_lane_buffer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready,
    output logic             busy
);

    logic [SEL_W-1:0] sel;
    logic             accept;
    logic [LANES-1:0] load;
    logic [WIDTH-1:0] y_lane [LANES];

`ifdef DEMUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             unused_sel;

    assign unused_sel = s1 ^ s0;
    assign sel        = rr_ptr;

    // Pointer moves only on an accepted word, so a stalled lane keeps being targeted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end
`else
    assign sel = {s1, s0};
`endif

    assign in_ready = ~y_valid[sel] | y_ready[sel];
    assign accept   = in_valid & in_ready;
    assign busy     = |y_valid;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign load[g] = accept & (sel == SEL_W'(g));

        demux_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load[g]),
            .din     (d),
            .y       (y_lane[g]),
            .y_valid (y_valid[g]),
            .y_ready (y_ready[g])
        );
    end

    assign y0 = y_lane[0];
    assign y1 = y_lane[1];
    assign y2 = y_lane[2];
    assign y3 = y_lane[3];

endmodule
